// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Fetch entries pair an instruction word with the address it was fetched from.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_checker.sv
// Protocol and occupancy properties for the fetch front-end.
// Bound to internal signals of instr_fetch_unit; has no functional outputs.
module fetch_checker (
  input logic        clk,
  input logic        resetn,
  input logic        imem_req,
  input logic        imem_gnt,
  input logic [31:0] imem_addr,
  input logic        imem_rvalid,
  input logic        redirect_valid,
  input logic        out_cnt_zero,
  input logic        fifo_full,
  input logic        fifo_push,
  input logic        fifo_pop
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    (fifo_push && fifo_full) |-> fifo_pop)
    else $error("fetch_checker: push into full buffer without pop");

  a_rvalid_credit: assert property (@(posedge clk) disable iff (!resetn)
    imem_rvalid |-> !out_cnt_zero)
    else $error("fetch_checker: response with nothing outstanding");

  // An ungranted request may only be withdrawn by a redirect
  a_req_hold: assert property (@(posedge clk) disable iff (!resetn)
    (imem_req && !imem_gnt) |=> (redirect_valid || (imem_req && (imem_addr == $past(imem_addr)))))
    else $error("fetch_checker: request dropped or changed before grant");

endmodule

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with registered head outputs.
// Flush has priority over push and pop; storage contents are kept across a flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wr_entry,
  output fetch_entry_t     rd_entry,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointer, occupancy and storage next-state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != {CNT_W{1'b0}});
    do_push  = push && ((count_q != DEPTH_CNT) || do_pop);
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_entry = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == DEPTH_CNT);
  assign empty    = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front-end: owns the PC, issues credit-limited word requests, discards
// responses that were in flight at a redirect, and buffers instructions for decode.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);

  localparam int               CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int               SUM_W     = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(FIFO_DEPTH);
  localparam logic [31:0]      PC_STEP   = 32'(INSTR_BYTES);

  logic             active_q, active_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic [SUM_W-1:0] credit_used;
  logic             pop;
  logic             grant;
  logic             resp_ok;
  logic             resp_keep;
  logic             push;

  // Credits cover both in-flight and buffered fetches, so the buffer can never overflow
  always_comb begin
    pop         = !fifo_empty && instr_ready;
    credit_used = {1'b0, out_cnt_q} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, pop};
    imem_req    = active_q && !redirect_valid && (credit_used < DEPTH_SUM);
    grant       = imem_req && imem_gnt;
    resp_ok     = imem_rvalid && (out_cnt_q != {CNT_W{1'b0}});
    resp_keep   = resp_ok && (drop_cnt_q == {CNT_W{1'b0}});
    push        = resp_keep && !redirect_valid;
    push_entry  = '{pc: resp_pc_q, instr: imem_rdata};
  end

  always_comb begin
    active_d   = 1'b1;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_cnt_d = drop_cnt_q;
    out_cnt_d  = out_cnt_q + CNT_W'(grant) - CNT_W'(resp_ok);
    if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      drop_cnt_d = out_cnt_d;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (resp_ok && !resp_keep) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      if (resp_keep) begin
        resp_pc_d = resp_pc_q + PC_STEP;
      end else begin
        resp_pc_d = resp_pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      active_q   <= 1'b0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= {CNT_W{1'b0}};
      drop_cnt_q <= {CNT_W{1'b0}};
    end else begin
      active_q   <= active_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (push_entry),
    .rd_entry (head_entry),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  fetch_checker u_checker (
    .clk            (clk),
    .resetn         (resetn),
    .imem_req       (imem_req),
    .imem_gnt       (imem_gnt),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .redirect_valid (redirect_valid),
    .out_cnt_zero   (out_cnt_q == {CNT_W{1'b0}}),
    .fifo_full      (fifo_full),
    .fifo_push      (push),
    .fifo_pop       (pop)
  );

  assign imem_addr   = fetch_pc_q;
  assign instr_valid = !fifo_empty;
  assign instr_data  = head_entry.instr;
  assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit with an in-order memory model
// whose responses come one cycle after grant unless held back.
module tb_instr_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_A5A5;
  localparam int NV = 36;

  logic        clk;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rdy;
    logic        gnt;
    logic        hold;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  vec_t        vecs [NV];
  logic [31:0] rsp_q [$];
  logic        rsp_hold;
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_vld;
  logic [31:0] s_data;
  logic [31:0] s_pc;
  int          n_checks;
  int          n_errors;

  function automatic vec_t mk(input logic rdy, input logic gnt, input logic hold,
                              input logic redir, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.gnt = gnt; v.hold = hold; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: present memory response, sample outputs at negedge, advance model at posedge
  task automatic step();
    if (resetn && !rsp_hold && (rsp_q.size() > 0)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = rsp_q[0] ^ K;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0000_0000;
    end
    #4;
    s_req  = imem_req;
    s_addr = imem_addr;
    s_vld  = instr_valid;
    s_data = instr_data;
    s_pc   = instr_pc;
    @(posedge clk);
    if (resetn && s_req && imem_gnt) rsp_q.push_back(s_addr);
    if (imem_rvalid) void'(rsp_q.pop_front());
    if (!resetn) rsp_q.delete();
    #1;
  endtask

  task automatic run_row(input int i);
    instr_ready    = vecs[i].rdy;
    imem_gnt       = vecs[i].gnt;
    rsp_hold       = vecs[i].hold;
    redirect_valid = vecs[i].redir;
    redirect_pc    = vecs[i].rpc;
    step();
    chk($sformatf("row%0d req", i), {31'd0, s_req}, {31'd0, vecs[i].e_req});
    chk($sformatf("row%0d addr", i), s_addr, vecs[i].e_addr);
    chk($sformatf("row%0d valid", i), {31'd0, s_vld}, {31'd0, vecs[i].e_vld});
    if (vecs[i].e_vld) begin
      chk($sformatf("row%0d pc", i), s_pc, vecs[i].e_pc);
      chk($sformatf("row%0d data", i), s_data, vecs[i].e_pc ^ K);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " req"}, {31'd0, s_req}, 32'd0);
    chk({tag, " addr"}, s_addr, 32'h0000_0000);
    chk({tag, " valid"}, {31'd0, s_vld}, 32'd0);
    chk({tag, " data"}, s_data, 32'h0000_0000);
    chk({tag, " pc"}, s_pc, 32'h0000_0000);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    // rdy gnt hold redir rpc | req addr vld pc
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h004);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h008);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h014, 1'b1, 32'h00C);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h014, 1'b1, 32'h00C);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h014, 1'b1, 32'h00C);
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h00C);
    vecs[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h018, 1'b1, 32'h010);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h01C, 1'b1, 32'h014);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h020, 1'b1, 32'h018);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h020, 1'b1, 32'h01C);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h020, 1'b0, 32'h000);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h020, 1'b0, 32'h000);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h020, 1'b0, 32'h000);
    vecs[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h020, 1'b0, 32'h000);
    vecs[17] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h024, 1'b0, 32'h000);
    vecs[18] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h028, 1'b1, 32'h020);
    vecs[19] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h02C, 1'b1, 32'h024);
    vecs[20] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h103, 1'b0, 32'h02C, 1'b0, 32'h000);
    vecs[21] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000);
    vecs[22] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h000);
    vecs[23] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000);
    vecs[24] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100);
    vecs[25] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104);
    vecs[26] = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h110, 1'b1, 32'h108);
    vecs[27] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000);
    vecs[28] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h000);
    vecs[29] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h200);
    vecs[30] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h20C, 1'b1, 32'h204);
    vecs[31] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 32'h210, 1'b0, 32'h000);
    vecs[32] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h300, 1'b0, 32'h000);
    vecs[33] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h000);
    vecs[34] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h304, 1'b0, 32'h000);
    vecs[35] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h308, 1'b1, 32'h300);

    resetn         = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0000_0000;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    instr_ready    = 1'b0;
    rsp_hold       = 1'b0;

    step();
    step();
    reset_checks("init_reset");
    resetn = 1'b1;
    step();

    for (int i = 0; i < NV; i++) run_row(i);

    // Reset in the middle of streaming, held for three cycles
    instr_ready = 1'b1;
    imem_gnt    = 1'b1;
    resetn      = 1'b0;
    step();
    step();
    reset_checks("mid_reset1");
    step();
    reset_checks("mid_reset2");
    resetn = 1'b1;
    step();
    for (int i = 0; i < 5; i++) run_row(i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
